// File: rtl/isa_fifo_port.sv
// isa_fifo_port: XT 8-bit I/O channel responder with wait states and a device-to-host FIFO.
// Define ISA_FIFO_PORT_DMA_EN to build the DMA requester (DRQ/DACK/TC) path.
module isa_fifo_port #(
  parameter logic [9:0] BASE_ADDRESS = 10'h300,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         WAIT_STATES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_out_en,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        address_enable_n,
  output logic        io_channel_ready,
  output logic        interrupt_request,
  output logic        dma_request,
  input  logic        dma_acknowledge_n,
  input  logic        terminal_count_n,
  input  logic        push_valid,
  input  logic [7:0]  push_data,
  output logic        push_ready,
  output logic        out_valid,
  output logic [7:0]  out_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          ior_prev;
  logic          iow_prev;
  logic          win_hit;
  logic          cpu_sel;
  logic          dma_sel;
  logic          ior_fall;
  logic          ior_rise;
  logic          iow_fall;
  logic          iow_rise;
  logic          acc_rd_data;
  logic          acc_rd_stat;
  logic          acc_dma;
  logic          acc_wr_data;
  logic          acc_wr_ctrl;
  logic [7:0]    wr_byte;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          not_empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          fifo_clear;
  logic          irq_en;
  logic          dma_en;
  logic          tc_seen;
  logic [7:0]    head;
  logic [7:0]    status;
  logic          stat_done;
  logic          wr_data_done;
  logic          wr_ctrl_done;
  logic          unused_bits;

  assign win_hit = address[9:1] == BASE_ADDRESS[9:1];

`ifdef ISA_FIFO_PORT_DMA_EN
  assign cpu_sel = address_enable_n & dma_acknowledge_n & win_hit;
  assign dma_sel = ~dma_acknowledge_n & ~io_read_n;
`else
  assign cpu_sel = address_enable_n & win_hit;
  assign dma_sel = 1'b0;
`endif

  assign ior_fall = ior_prev & ~io_read_n;
  assign ior_rise = ~ior_prev & io_read_n;
  assign iow_fall = iow_prev & ~io_write_n;
  assign iow_rise = ~iow_prev & io_write_n;

  // Access kind is captured at the strobe's falling edge and acted on at its rise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ior_prev    <= 1'b1;
      iow_prev    <= 1'b1;
      acc_rd_data <= 1'b0;
      acc_rd_stat <= 1'b0;
      acc_dma     <= 1'b0;
      acc_wr_data <= 1'b0;
      acc_wr_ctrl <= 1'b0;
      wr_byte     <= 8'h00;
    end else begin
      ior_prev <= io_read_n;
      iow_prev <= io_write_n;
      if (ior_fall) begin
        acc_rd_data <= cpu_sel & ~address[0];
        acc_rd_stat <= cpu_sel & address[0];
        acc_dma     <= dma_sel;
      end
      if (iow_fall) begin
        acc_wr_data <= cpu_sel & ~address[0];
        acc_wr_ctrl <= cpu_sel & address[0];
      end
      if (~io_write_n & cpu_sel)
        wr_byte <= data_bus_in;
    end
  end

  assign pop          = ior_rise & (acc_rd_data | acc_dma) & not_empty;
  assign stat_done    = ior_rise & acc_rd_stat;
  assign wr_data_done = iow_rise & acc_wr_data;
  assign wr_ctrl_done = iow_rise & acc_wr_ctrl;
  assign fifo_clear   = wr_ctrl_done & wr_byte[2];

  assign not_empty  = count != '0;
  assign full       = count == CW'(FIFO_DEPTH);
  assign push_ready = ~full;
  assign push       = push_valid & ~full;
  assign head       = mem[rd_ptr];
  assign status     = {3'b000, dma_en, irq_en, tc_seen, full, not_empty};

  always_ff @(posedge clock) begin
    if (push & ~fifo_clear)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    data_bus_out    = 8'h00;
    data_bus_out_en = (cpu_sel & ~io_read_n) | dma_sel;
    unique case (1'b1)
      cpu_sel & ~io_read_n & address[0]:
        data_bus_out = status;
      (cpu_sel & ~io_read_n & ~address[0]) | dma_sel:
        data_bus_out = not_empty ? head : 8'hFF;
      default:
        data_bus_out = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if ((ior_fall | iow_fall) & (cpu_sel | dma_sel)) begin
            if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_STATES);
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1)
            state <= S_DONE;
        end
        S_DONE: begin
          if (io_read_n & io_write_n)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io_channel_ready = state != S_WAIT;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_en            <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      interrupt_request <= 1'b0;
    end else begin
      out_valid <= wr_data_done;
      if (wr_data_done)
        out_data <= wr_byte;
      if (wr_ctrl_done)
        irq_en <= wr_byte[1];
      interrupt_request <= irq_en & (not_empty | tc_seen);
    end
  end

`ifdef ISA_FIFO_PORT_DMA_EN
  logic tc_hit;
  logic dma_done;

  assign dma_done = ior_rise & acc_dma;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tc_hit <= 1'b0;
    else if (ior_fall)
      tc_hit <= dma_sel & ~terminal_count_n;
    else if (dma_sel & ~terminal_count_n)
      tc_hit <= 1'b1;
  end

  // DRQ is held off in the pop clock so it never reflects a stale count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dma_en      <= 1'b0;
      tc_seen     <= 1'b0;
      dma_request <= 1'b0;
    end else begin
      if (wr_ctrl_done)
        dma_en <= wr_byte[0];
      if (dma_done & tc_hit) begin
        tc_seen <= 1'b1;
        dma_en  <= 1'b0;
      end else if (stat_done) begin
        tc_seen <= 1'b0;
      end
      dma_request <= dma_en & not_empty & dma_acknowledge_n & ~ior_rise;
    end
  end

  assign unused_bits = ^{address[19:10]};
`else
  assign dma_en      = 1'b0;
  assign tc_seen     = 1'b0;
  assign dma_request = 1'b0;
  assign unused_bits = ^{address[19:10], dma_acknowledge_n,
                         terminal_count_n, stat_done};
`endif

endmodule

// File: tb/tb_isa_fifo_port.sv
// tb_isa_fifo_port: scoreboard bench for isa_fifo_port bus reads, writes and FIFO.
// DMA sequences are compiled in when ISA_FIFO_PORT_DMA_EN is defined.
module tb_isa_fifo_port;

  localparam int WS    = 2;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [7:0]  data_bus_in;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_en;
  logic        io_read_n;
  logic        io_write_n;
  logic        address_enable_n;
  logic        io_channel_ready;
  logic        interrupt_request;
  logic        dma_request;
  logic        dma_acknowledge_n;
  logic        terminal_count_n;
  logic        push_valid;
  logic [7:0]  push_data;
  logic        push_ready;
  logic        out_valid;
  logic [7:0]  out_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rd_q[$];
  logic [7:0] out_q[$];
  logic [7:0] model[$];

  isa_fifo_port #(
    .BASE_ADDRESS(10'h300),
    .FIFO_DEPTH  (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .address          (address),
    .data_bus_in      (data_bus_in),
    .data_bus_out     (data_bus_out),
    .data_bus_out_en  (data_bus_out_en),
    .io_read_n        (io_read_n),
    .io_write_n       (io_write_n),
    .address_enable_n (address_enable_n),
    .io_channel_ready (io_channel_ready),
    .interrupt_request(interrupt_request),
    .dma_request      (dma_request),
    .dma_acknowledge_n(dma_acknowledge_n),
    .terminal_count_n (terminal_count_n),
    .push_valid       (push_valid),
    .push_data        (push_data),
    .push_ready       (push_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a read completes when the bus drive drops; out_valid is a write
  initial begin : monitor
    logic [7:0] rd_last;
    bit         rd_act;
    rd_act  = 1'b0;
    rd_last = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        rd_act = 1'b0;
      end else begin
        if (data_bus_out_en) begin
          rd_last = data_bus_out;
          rd_act  = 1'b1;
        end else if (rd_act) begin
          rd_act = 1'b0;
          if (rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected: got %0h expected none", rd_last);
          end else begin
            chk("rd_data", rd_last, rd_q.pop_front());
          end
        end
      end
      if (out_valid) begin
        if (out_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got %0h expected none", out_data);
        end else begin
          chk("out_data", out_data, out_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] d);
    @(negedge clock);
    push_valid = 1'b1;
    push_data  = d;
    if (model.size() < DEPTH)
      model.push_back(d);
    @(negedge clock);
    push_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [19:0] a, input logic [7:0] e,
                          input bit do_push, input logic [7:0] pd,
                          input string nm);
    int lows;
    lows = 0;
    rd_q.push_back(e);
    @(negedge clock);
    address = a;
    @(negedge clock);
    io_read_n = 1'b0;
    repeat (WS + 3) begin
      @(negedge clock);
      if (!io_channel_ready)
        lows++;
    end
    io_read_n = 1'b1;
    if (do_push) begin
      push_valid = 1'b1;
      push_data  = pd;
    end
    @(negedge clock);
    push_valid = 1'b0;
    @(negedge clock);
    chk({nm, "_wait"}, lows, WS);
  endtask

  task automatic read_data(input bit do_push, input logic [7:0] pd,
                           input string nm);
    logic [7:0] e;
    bit         acc;
    acc = model.size() < DEPTH;
    e   = 8'hFF;
    if (model.size() != 0)
      e = model.pop_front();
    if (do_push && acc)
      model.push_back(pd);
    bus_read(20'h00300, e, do_push, pd, nm);
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [7:0] d,
                           input logic aen, input string nm);
    int lows;
    lows = 0;
    if (aen && a[9:1] == 9'h180 && !a[0])
      out_q.push_back(d);
    @(negedge clock);
    address          = a;
    data_bus_in      = d;
    address_enable_n = aen;
    @(negedge clock);
    io_write_n = 1'b0;
    repeat (WS + 3) begin
      @(negedge clock);
      if (!io_channel_ready)
        lows++;
    end
    io_write_n = 1'b1;
    @(negedge clock);
    address_enable_n = 1'b1;
    @(negedge clock);
    chk({nm, "_wait"}, lows, aen ? WS : 0);
  endtask

`ifdef ISA_FIFO_PORT_DMA_EN
  task automatic dma_cycle(input bit tc, input string nm);
    int         lows;
    logic [7:0] e;
    lows = 0;
    e    = 8'hFF;
    if (model.size() != 0)
      e = model.pop_front();
    rd_q.push_back(e);
    @(negedge clock);
    address           = 20'h00000;
    dma_acknowledge_n = 1'b0;
    @(negedge clock);
    chk({nm, "_drq_ack"}, dma_request, 1'b0);
    io_read_n        = 1'b0;
    terminal_count_n = !tc;
    repeat (WS + 3) begin
      @(negedge clock);
      if (!io_channel_ready)
        lows++;
    end
    io_read_n         = 1'b1;
    dma_acknowledge_n = 1'b1;
    terminal_count_n  = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk({nm, "_wait"}, lows, WS);
  endtask
`endif

  initial begin
    reset             = 1'b1;
    address           = 20'h00000;
    data_bus_in       = 8'h00;
    io_read_n         = 1'b1;
    io_write_n        = 1'b1;
    address_enable_n  = 1'b1;
    dma_acknowledge_n = 1'b1;
    terminal_count_n  = 1'b1;
    push_valid        = 1'b0;
    push_data         = 8'h00;

    repeat (3) @(negedge clock);
    chk("rst_dout", data_bus_out, 8'h00);
    chk("rst_den", data_bus_out_en, 1'b0);
    chk("rst_ready", io_channel_ready, 1'b1);
    chk("rst_irq", interrupt_request, 1'b0);
    chk("rst_drq", dma_request, 1'b0);
    chk("rst_pready", push_ready, 1'b1);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_odata", out_data, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    bus_read(20'h00301, 8'h00, 1'b0, 8'h00, "stat0");
    chk("stat0_irq", interrupt_request, 1'b0);

    push_byte(8'hA5);
    push_byte(8'h3C);
    read_data(1'b0, 8'h00, "rdA5");
    read_data(1'b0, 8'h00, "rd3C");
    read_data(1'b0, 8'h00, "rdFF");
    bus_read(20'h00301, 8'h00, 1'b0, 8'h00, "stat_empty");

    for (int i = 0; i < DEPTH; i++)
      push_byte(8'h10 + 8'(i));
    chk("full_pready", push_ready, 1'b0);
    push_byte(8'hEE);
    bus_read(20'h00301, 8'h02 | 8'h01, 1'b0, 8'h00, "stat_full");
    read_data(1'b0, 8'h00, "rd_at16");
    chk("cnt15_pready", push_ready, 1'b1);
    read_data(1'b1, 8'h99, "rd_push15");
    chk("pushpop_pready", push_ready, 1'b1);
    push_byte(8'h98);
    chk("refill_pready", push_ready, 1'b0);
    read_data(1'b0, 8'h00, "rd_a");
    read_data(1'b0, 8'h00, "rd_b");
    bus_write(20'h00301, 8'h04, 1'b1, "clear");
    model.delete();
    bus_read(20'h00301, 8'h00, 1'b0, 8'h00, "stat_clr");
    chk("clr_pready", push_ready, 1'b1);

    push_byte(8'hA1);
    bus_write(20'h00301, 8'h02, 1'b1, "irq_en");
    chk("irq_on", interrupt_request, 1'b1);
    read_data(1'b0, 8'h00, "rdA1");
    chk("irq_off", interrupt_request, 1'b0);
    bus_write(20'h00301, 8'h00, 1'b1, "ctrl0");

`ifdef ISA_FIFO_PORT_DMA_EN
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    bus_write(20'h00301, 8'h01, 1'b1, "dma_en");
    chk("drq_on", dma_request, 1'b1);
    dma_cycle(1'b0, "dma1");
    chk("drq_re1", dma_request, 1'b1);
    dma_cycle(1'b0, "dma2");
    chk("drq_re2", dma_request, 1'b1);
    dma_cycle(1'b1, "dma3");
    chk("drq_tc", dma_request, 1'b0);
    bus_read(20'h00301, 8'h04, 1'b0, 8'h00, "stat_tc");
    bus_read(20'h00301, 8'h00, 1'b0, 8'h00, "stat_tcclr");
`else
    push_byte(8'h5A);
    bus_write(20'h00301, 8'h01, 1'b1, "dma_ign");
    repeat (2) @(negedge clock);
    chk("drq_tied", dma_request, 1'b0);
    bus_read(20'h00301, 8'h01, 1'b0, 8'h00, "stat_nodma");
    bus_write(20'h00301, 8'h04, 1'b1, "clear2");
    model.delete();
`endif

    bus_write(20'h00300, 8'h77, 1'b0, "wr_aen0");
    bus_write(20'h00300, 8'h77, 1'b1, "wr_aen1");
    bus_write(20'h00300, 8'hC3, 1'b1, "wr_c3");

    // Reset in the middle of a write's wait window
    @(negedge clock);
    address     = 20'h00300;
    data_bus_in = 8'h55;
    @(negedge clock);
    io_write_n = 1'b0;
    @(negedge clock);
    chk("mid_ready_lo", io_channel_ready, 1'b0);
    #2 reset = 1'b1;
    #1 chk("mid_ready_hi", io_channel_ready, 1'b1);
    @(negedge clock);
    io_write_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_ovalid", out_valid, 1'b0);

    repeat (4) @(negedge clock);
    chk("rd_q_left", rd_q.size(), 0);
    chk("out_q_left", out_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
